time_counter: RTL and testbench
===============================

// Module: time_counter
// PURPOSE
//  24-hour BCD time-of-day counter with a 1 Hz prescaler and a button-driven set mode.
//  Produces the packed 20-bit time word consumed directly by display_ctrl.disp_time.
//  Sits between the debounced button pulses and the 7-segment display controller.
// PARAMETERS
//  CLK_FREQ   100_000_000   clk cycles per second; prescaler terminal count is CLK_FREQ-1 (>=2)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset
//  btn_mode   in   1   single-cycle pulse: advance mode RUN->SET_H->SET_M->RUN
//  btn_inc    in   1   single-cycle pulse: increment field selected by current set mode
//  cur_time   out  20  packed BCD time: [19:18] H tens, [17:14] H units, [13:11] M tens,
//                      [10:7] M units, [6:4] S tens, [3:0] S units
//  sec_tick   out  1   one-cycle pulse, high in the cycle cur_time shows the advanced second
//  set_mode   out  2   2'b00 RUN, 2'b01 SET_H, 2'b10 SET_M (2'b11 never driven)
// BEHAVIOUR
//  Reset (reset==0, async assert, sync release): cur_time=20'h0 (00:00:00), sec_tick=0,
//   set_mode=RUN, prescaler=0. All outputs are registered.
//  Prescaler (RUN only): counts 0..CLK_FREQ-1; at terminal it wraps to 0 and the time
//   advances one second on the same edge; sec_tick=1 for exactly that following cycle.
//   Between consecutive ticks: exactly CLK_FREQ cycles. Held at 0 in SET_H/SET_M.
//  Seconds/minutes carry chain, all BCD, units first:
//   S units 9->0 carries to S tens; S tens 5->0 (at S=59) carries to M units;
//   M units 9->0 -> M tens; M tens 5->0 (M=59) carries to hours.
//   Hours: H units 9->0 with H tens +1; 23 -> 00 (H tens 2 & H units 3 -> both 0).
//   23:59:59 + 1 s -> 00:00:00 in a single edge. Fields never hold non-BCD values.
//  Mode FSM, transitions on btn_mode only:
//   RUN   --btn_mode--> SET_H ; btn_inc ignored.
//   SET_H --btn_mode--> SET_M ; btn_inc: hours +1 (BCD), 23->00, no carry elsewhere.
//   SET_M --btn_mode--> RUN   ; btn_inc: minutes +1 (BCD), 59->00, no carry to hours.
//   Exit SET_M->RUN: seconds cleared to 00 and prescaler cleared on the same edge;
//    first sec_tick follows exactly CLK_FREQ cycles later.
//   Entering SET_H: seconds frozen (not cleared); no sec_tick while in SET_H/SET_M.
//  Simultaneous btn_mode and btn_inc in one cycle: mode change wins, increment dropped.
//  btn_inc coinciding with a prescaler terminal in RUN: inc ignored, tick proceeds normally.
//  Held (multi-cycle) btn_inc in set mode increments once per high cycle; debouncing and
//   edge detection are upstream responsibilities.
//  Reset asserted mid-operation (any state, mid-prescale): immediate return to reset values.
// TESTING (CLK_FREQ=4 in simulation)
//  1 Reset low 3 cycles, release -> cur_time=20'h0, set_mode=0, sec_tick=0; first sec_tick
//    after exactly 4 cycles, cur_time S units=1; after 10 ticks S=10 (S tens=1, units=0).
//  2 btn_mode, 23x btn_inc, btn_mode, 59x btn_inc, btn_mode -> 23:59:00, set_mode=0;
//    run 59 ticks -> 23:59:59, next tick -> cur_time=20'h0 and sec_tick=1 same cycle.
//  3 SET_H from 00: 24x btn_inc -> hours 23 then 00; minutes and seconds unchanged;
//    SET_M: 60x btn_inc -> minutes wraps to 00, hours unchanged.
//  4 In SET_H assert btn_mode and btn_inc same cycle -> set_mode=2'b10, hours unchanged;
//    btn_inc in RUN -> cur_time unchanged except normal ticks.
//  5 Time at 12:34:56, enter SET_H, wait 20 cycles -> no sec_tick, seconds stay 56; finish
//    SET_M -> seconds 00, next sec_tick exactly 4 cycles after return to RUN.
//  6 Assert reset 2 cycles into a prescale period at 05:07:09 (async, between edges)
//    -> outputs go to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/time_counter.sv
// time_counter: 24-hour BCD time-of-day counter with 1 Hz prescaler and button-driven set mode
//   clk       system clock
//   reset     asynchronous active-low reset
//   btn_mode  one-cycle pulse, cycles RUN -> SET_H -> SET_M -> RUN
//   btn_inc   one-cycle pulse, increments the field selected by the set mode
//   cur_time  packed BCD {Ht[1:0],Hu[3:0],Mt[2:0],Mu[3:0],St[2:0],Su[3:0]}
//   sec_tick  one-cycle pulse in the cycle cur_time shows the advanced second
//   set_mode  2'b00 RUN, 2'b01 SET_H, 2'b10 SET_M
module time_counter #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [19:0] cur_time,
    output logic        sec_tick,
    output logic [1:0]  set_mode
);
    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] TERM = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {RUN = 2'b00, SET_H = 2'b01, SET_M = 2'b10} mode_e;

    mode_e         mode_q, mode_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    ht_q, ht_d;
    logic [3:0]    hu_q, hu_d;
    logic [2:0]    mt_q, mt_d;
    logic [3:0]    mu_q, mu_d;
    logic [2:0]    st_q, st_d;
    logic [3:0]    su_q, su_d;
    logic          tick_q, tick_d;

    // Field-wise +1 values with BCD wrap; each field wraps independently so the
    // same values serve both the seconds carry chain and the set-mode increments.
    logic       s_wrap, m_wrap, h_wrap;
    logic [3:0] su_inc, mu_inc, hu_inc;
    logic [2:0] st_inc, mt_inc;
    logic [1:0] ht_inc;

    always_comb begin
        s_wrap = (st_q == 3'd5) && (su_q == 4'd9);
        m_wrap = (mt_q == 3'd5) && (mu_q == 4'd9);
        h_wrap = (ht_q == 2'd2) && (hu_q == 4'd3);
        su_inc = (su_q == 4'd9) ? 4'd0 : su_q + 4'd1;
        st_inc = s_wrap ? 3'd0 : (su_q == 4'd9) ? st_q + 3'd1 : st_q;
        mu_inc = (mu_q == 4'd9) ? 4'd0 : mu_q + 4'd1;
        mt_inc = m_wrap ? 3'd0 : (mu_q == 4'd9) ? mt_q + 3'd1 : mt_q;
        hu_inc = (h_wrap || hu_q == 4'd9) ? 4'd0 : hu_q + 4'd1;
        ht_inc = h_wrap ? 2'd0 : (hu_q == 4'd9) ? ht_q + 2'd1 : ht_q;
    end

    always_comb begin
        mode_d = mode_q;
        pre_d  = '0;
        ht_d   = ht_q;
        hu_d   = hu_q;
        mt_d   = mt_q;
        mu_d   = mu_q;
        st_d   = st_q;
        su_d   = su_q;
        tick_d = 1'b0;
        if (mode_q == RUN) begin
            if (btn_mode) begin
                mode_d = SET_H;
            end else if (pre_q == TERM) begin
                tick_d = 1'b1;
                su_d   = su_inc;
                st_d   = st_inc;
                if (s_wrap) begin
                    mu_d = mu_inc;
                    mt_d = mt_inc;
                    if (m_wrap) begin
                        hu_d = hu_inc;
                        ht_d = ht_inc;
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end else if (mode_q == SET_H) begin
            if (btn_mode) begin
                mode_d = SET_M;
            end else if (btn_inc) begin
                hu_d = hu_inc;
                ht_d = ht_inc;
            end
        end else begin
            // Leaving SET_M restarts the second from a clean boundary.
            if (btn_mode) begin
                mode_d = RUN;
                st_d   = 3'd0;
                su_d   = 4'd0;
            end else if (btn_inc) begin
                mu_d = mu_inc;
                mt_d = mt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= RUN;
            pre_q  <= '0;
            ht_q   <= '0;
            hu_q   <= '0;
            mt_q   <= '0;
            mu_q   <= '0;
            st_q   <= '0;
            su_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pre_q  <= pre_d;
            ht_q   <= ht_d;
            hu_q   <= hu_d;
            mt_q   <= mt_d;
            mu_q   <= mu_d;
            st_q   <= st_d;
            su_q   <= su_d;
            tick_q <= tick_d;
        end
    end

    assign cur_time = {ht_q, hu_q, mt_q, mu_q, st_q, su_q};
    assign sec_tick = tick_q;
    assign set_mode = mode_q;
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed vector table plus multi-cycle sequences for time_counter
module tb_time_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [19:0] cur_time;
    logic        sec_tick;
    logic [1:0]  set_mode;
    int          n_chk = 0;
    int          n_fail = 0;

    time_counter #(.CLK_FREQ(4)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_time(cur_time), .sec_tick(sec_tick), .set_mode(set_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic        i;
        logic [19:0] t;
        logic [1:0]  md;
        logic        tk;
    } vec_t;

    function automatic logic [19:0] pk(int h, int m, int s);
        pk = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(string nm, logic [19:0] act, logic [19:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(logic m, logic i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b0);
            n++;
            if (sec_tick) break;
        end
        chk("tick_seen", 20'(sec_tick), 20'd1);
    endtask

    task automatic run_ticks(int cnt);
        int n;
        for (int k = 0; k < cnt; k++) wait_tick(n);
    endtask

    task automatic set_time(int h, int m);
        cyc(1'b1, 1'b0);
        repeat (h) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        repeat (m) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[13];
        int   n;
        int   ticks;
        v[0]  = '{1'b0, 1'b1, pk(0, 0, 0), 2'd0, 1'b0};
        v[1]  = '{1'b0, 1'b0, pk(0, 0, 0), 2'd0, 1'b0};
        v[2]  = '{1'b0, 1'b0, pk(0, 0, 0), 2'd0, 1'b0};
        v[3]  = '{1'b0, 1'b1, pk(0, 0, 1), 2'd0, 1'b1};
        v[4]  = '{1'b1, 1'b0, pk(0, 0, 1), 2'd1, 1'b0};
        v[5]  = '{1'b0, 1'b1, pk(1, 0, 1), 2'd1, 1'b0};
        v[6]  = '{1'b1, 1'b1, pk(1, 0, 1), 2'd2, 1'b0};
        v[7]  = '{1'b0, 1'b1, pk(1, 1, 1), 2'd2, 1'b0};
        v[8]  = '{1'b1, 1'b0, pk(1, 1, 0), 2'd0, 1'b0};
        v[9]  = '{1'b0, 1'b0, pk(1, 1, 0), 2'd0, 1'b0};
        v[10] = '{1'b0, 1'b0, pk(1, 1, 0), 2'd0, 1'b0};
        v[11] = '{1'b0, 1'b0, pk(1, 1, 0), 2'd0, 1'b0};
        v[12] = '{1'b0, 1'b0, pk(1, 1, 1), 2'd0, 1'b1};

        do_reset();
        chk("rst_time", cur_time, pk(0, 0, 0));
        chk("rst_mode", 20'(set_mode), 20'd0);
        chk("rst_tick", 20'(sec_tick), 20'd0);
        for (int k = 0; k < 13; k++) begin
            cyc(v[k].m, v[k].i);
            chk($sformatf("vec%0d_time", k), cur_time, v[k].t);
            chk($sformatf("vec%0d_mode", k), 20'(set_mode), 20'(v[k].md));
            chk($sformatf("vec%0d_tick", k), 20'(sec_tick), 20'(v[k].tk));
        end

        do_reset();
        chk("t1_rst_time", cur_time, 20'h0);
        wait_tick(n);
        chk("t1_first_tick_cycles", 20'(n), 20'd4);
        chk("t1_first_tick_time", cur_time, pk(0, 0, 1));
        run_ticks(9);
        chk("t1_ten_secs", cur_time, 20'h00010);

        cyc(1'b1, 1'b0);
        repeat (23) cyc(1'b0, 1'b1);
        chk("t3_hours23", cur_time, pk(23, 0, 10));
        cyc(1'b0, 1'b1);
        chk("t3_hours_wrap", cur_time, pk(0, 0, 10));
        cyc(1'b1, 1'b0);
        repeat (59) cyc(1'b0, 1'b1);
        chk("t3_min59", cur_time, pk(0, 59, 10));
        cyc(1'b0, 1'b1);
        chk("t3_min_wrap", cur_time, pk(0, 0, 10));
        cyc(1'b1, 1'b0);
        chk("t3_exit_clear", cur_time, pk(0, 0, 0));

        set_time(23, 59);
        chk("t2_set_time", cur_time, 20'h8EC80);
        chk("t2_mode_run", 20'(set_mode), 20'd0);
        run_ticks(59);
        chk("t2_235959", cur_time, 20'h8ECD9);
        wait_tick(n);
        chk("t2_midnight_time", cur_time, 20'h0);
        chk("t2_midnight_tick", 20'(sec_tick), 20'd1);

        set_time(12, 34);
        run_ticks(56);
        chk("t5_123456", cur_time, pk(12, 34, 56));
        cyc(1'b1, 1'b0);
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b0);
            if (sec_tick) ticks++;
        end
        chk("t5_no_tick_in_set", 20'(ticks), 20'd0);
        chk("t5_secs_frozen", cur_time, pk(12, 34, 56));
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("t5_secs_cleared", cur_time, pk(12, 34, 0));
        wait_tick(n);
        chk("t5_tick_latency", 20'(n), 20'd4);
        chk("t5_tick_time", cur_time, pk(12, 34, 1));

        do_reset();
        set_time(5, 7);
        run_ticks(9);
        chk("t6_050709", cur_time, pk(5, 7, 9));
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        #3 reset = 1'b0;
        #1;
        chk("t6_async_time", cur_time, 20'h0);
        chk("t6_async_tick", 20'(sec_tick), 20'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b1, 1'b0);
        chk("t6_in_set_h", 20'(set_mode), 20'd1);
        #3 reset = 1'b0;
        #1;
        chk("t6_async_mode", 20'(set_mode), 20'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        wait_tick(n);
        chk("t6_prescale_cleared", 20'(n), 20'd4);
        chk("t6_after_reset_time", cur_time, pk(0, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
